topk_tracker: RTL and testbench

Streaming top-K tracker, the parametrised successor to the team's second-largest block. It accepts one WIDTH-bit unsigned sample per qualified clock and keeps a sorted register file of the K best samples seen since the last reset or clear. Best means largest or smallest, set by parameter. It outputs the K-th best value plus the full sorted list and sits on the datapath as a passive monitor. With K=2, DISTINCT=1, FIND_MIN=0 it reproduces second-largest behaviour, and it adds valid qualification, clear, fill count, min mode and duplicate policy.

---
 rtl/topk_if.sv | 28 ++
 rtl/topk_tracker.sv | 112 +++++++++++
 tb/tb_topk_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topk_if.sv
// Sample stream and result bus for the top-K tracker.
//   clear, in_valid, d_in      : master -> slave (sample side)
//   d_out, out_valid, count,
//   top_all                    : slave -> master (result side)
interface topk_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K     = 2
);
    localparam int unsigned CW = $clog2(K + 1);

    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic [K*WIDTH-1:0] top_all;

    modport master (
        output clear, in_valid, d_in,
        input  d_out, out_valid, count, top_all
    );

    modport slave (
        input  clear, in_valid, d_in,
        output d_out, out_valid, count, top_all
    );
endinterface

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: keeps the K best unsigned samples (largest or
// smallest) in a sorted register file, slot 0 being the best.
//   clk, reset      : rising-edge clock, async active-high reset
//   bus.clear       : synchronous clear, wins over bus.in_valid
//   bus.in_valid    : bus.d_in is sampled on this edge
//   bus.d_out       : K-th best entry once all K slots are filled, else 0
//   bus.out_valid   : count == K
//   bus.count       : number of filled slots, saturates at K
//   bus.top_all     : all slots packed, slot 0 at the low bits
module topk_tracker #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned K        = 2,
    parameter int unsigned FIND_MIN = 0,
    parameter int unsigned DISTINCT = 1
) (
    input  logic   clk,
    input  logic   reset,
    topk_if.slave  bus
);
    localparam int unsigned CW = $clog2(K + 1);

    logic [WIDTH-1:0]   slot_q    [K];
    logic [WIDTH-1:0]   slot_d    [K];
    logic [WIDTH-1:0]   prev_slot [K];
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [WIDTH-1:0]   d_out_q;
    logic               out_valid_q;
    logic [K-1:0]       filled;
    logic [K-1:0]       keep;
    logic [K-1:0]       prev_keep;
    logic [K-1:0]       hit;
    logic               dup;
    logic               take;
    logic [K*WIDTH-1:0] top_all_c;

    // Parallel compare: keep[i] marks filled slots better than or equal to
    // the sample. The list is sorted, so keep is a prefix and its length is
    // the insert position; equals stay ahead of the newcomer.
    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            filled[i] = (CW'(i) < count_q);
            hit[i]    = filled[i] && (slot_q[i] == bus.d_in);
            if (FIND_MIN != 0) begin
                keep[i] = filled[i] && (slot_q[i] <= bus.d_in);
            end else begin
                keep[i] = filled[i] && (slot_q[i] >= bus.d_in);
            end
        end
    end

    assign dup       = (DISTINCT != 0) && (|hit);
    assign take      = bus.in_valid && !dup && !keep[K-1];
    assign prev_keep = {keep[K-2:0], 1'b1};

    // Shift/insert mux: the first non-kept slot takes the sample, later
    // slots take their predecessor; unfilled slots shift in zeros.
    always_comb begin
        count_d      = count_q;
        prev_slot[0] = '0;
        for (int i = 0; i < int'(K); i++) begin
            slot_d[i] = slot_q[i];
        end
        for (int i = 1; i < int'(K); i++) begin
            prev_slot[i] = slot_q[i-1];
        end
        if (bus.clear) begin
            count_d = '0;
            for (int i = 0; i < int'(K); i++) begin
                slot_d[i] = '0;
            end
        end else if (take) begin
            count_d = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
            for (int i = 0; i < int'(K); i++) begin
                if (!keep[i]) begin
                    slot_d[i] = prev_keep[i] ? bus.d_in : prev_slot[i];
                end
            end
        end
    end

    // State and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(K); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            out_valid_q <= (count_d == CW'(K));
            d_out_q     <= (count_d == CW'(K)) ? slot_d[K-1] : '0;
            for (int i = 0; i < int'(K); i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_comb begin
        top_all_c = '0;
        for (int i = 0; i < int'(K); i++) begin
            top_all_c[i*WIDTH +: WIDTH] = slot_q[i];
        end
    end

    assign bus.count     = count_q;
    assign bus.d_out     = d_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.top_all   = top_all_c;
endmodule

// File: tb/tb_topk_tracker.sv
// Bench for topk_tracker: four instances covering the configurations of
// interest, checked against constant tables and a queue-based list model.
module tb_topk_tracker;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance configurations: {K, DISTINCT, FIND_MIN}
    int cfg_k    [4] = '{2, 2, 4, 3};
    int cfg_dist [4] = '{1, 0, 0, 1};
    int cfg_min  [4] = '{0, 0, 0, 1};

    logic         drv_clear [4];
    logic         drv_valid [4];
    logic [W-1:0] drv_d     [4];

    topk_if #(.WIDTH(W), .K(2)) if0 ();
    topk_if #(.WIDTH(W), .K(2)) if1 ();
    topk_if #(.WIDTH(W), .K(4)) if2 ();
    topk_if #(.WIDTH(W), .K(3)) if3 ();

    assign if0.clear = drv_clear[0]; assign if0.in_valid = drv_valid[0]; assign if0.d_in = drv_d[0];
    assign if1.clear = drv_clear[1]; assign if1.in_valid = drv_valid[1]; assign if1.d_in = drv_d[1];
    assign if2.clear = drv_clear[2]; assign if2.in_valid = drv_valid[2]; assign if2.d_in = drv_d[2];
    assign if3.clear = drv_clear[3]; assign if3.in_valid = drv_valid[3]; assign if3.d_in = drv_d[3];

    topk_tracker #(.WIDTH(W), .K(2), .FIND_MIN(0), .DISTINCT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    topk_tracker #(.WIDTH(W), .K(2), .FIND_MIN(0), .DISTINCT(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    topk_tracker #(.WIDTH(W), .K(4), .FIND_MIN(0), .DISTINCT(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    topk_tracker #(.WIDTH(W), .K(3), .FIND_MIN(1), .DISTINCT(1)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    // Observed outputs gathered into index-able arrays.
    logic [W-1:0] obs_slot  [4][16];
    int unsigned  obs_cnt   [4];
    logic [W-1:0] obs_dout  [4];
    logic         obs_ov    [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) obs_slot[i][j] = '0;
        end
        for (int j = 0; j < 2; j++) obs_slot[0][j] = if0.top_all[j*W +: W];
        for (int j = 0; j < 2; j++) obs_slot[1][j] = if1.top_all[j*W +: W];
        for (int j = 0; j < 4; j++) obs_slot[2][j] = if2.top_all[j*W +: W];
        for (int j = 0; j < 3; j++) obs_slot[3][j] = if3.top_all[j*W +: W];
        obs_cnt[0] = 32'(if0.count); obs_cnt[1] = 32'(if1.count);
        obs_cnt[2] = 32'(if2.count); obs_cnt[3] = 32'(if3.count);
        obs_dout[0] = if0.d_out; obs_dout[1] = if1.d_out;
        obs_dout[2] = if2.d_out; obs_dout[3] = if3.d_out;
        obs_ov[0] = if0.out_valid; obs_ov[1] = if1.out_valid;
        obs_ov[2] = if2.out_valid; obs_ov[3] = if3.out_valid;
    end

    // Reference model: the best-first list kept as plain arrays.
    int unsigned m_slot [4][16];
    int unsigned m_cnt  [4];
    int n_checks = 0;
    int n_fails  = 0;

    function automatic void model_clear(int idx);
        m_cnt[idx] = 0;
        for (int j = 0; j < 16; j++) m_slot[idx][j] = 0;
    endfunction

    function automatic void model_insert(int idx, int unsigned d);
        int unsigned q[$];
        int p;
        for (int j = 0; j < int'(m_cnt[idx]); j++) q.push_back(m_slot[idx][j]);
        if (cfg_dist[idx] != 0) begin
            foreach (q[j]) if (q[j] == d) return;
        end
        p = 0;
        foreach (q[j]) begin
            if (cfg_min[idx] != 0 ? (q[j] <= d) : (q[j] >= d)) p++;
        end
        if (p >= cfg_k[idx]) return;
        q.insert(p, d);
        if (q.size() > cfg_k[idx]) void'(q.pop_back());
        m_cnt[idx] = q.size();
        for (int j = 0; j < 16; j++) m_slot[idx][j] = (j < q.size()) ? q[j] : 0;
    endfunction

    function automatic int unsigned model_dout(int idx);
        return (m_cnt[idx] == cfg_k[idx]) ? m_slot[idx][cfg_k[idx]-1] : 0;
    endfunction

    // One clock of stimulus on one instance; the model follows the same rules.
    task automatic drive(int idx, bit v, bit c, int unsigned d);
        drv_valid[idx] = v;
        drv_clear[idx] = c;
        drv_d[idx]     = W'(d);
        @(posedge clk);
        #1;
        drv_valid[idx] = 1'b0;
        drv_clear[idx] = 1'b0;
        if (c) model_clear(idx);
        else if (v) model_insert(idx, d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_cnt[i] !== 0 || obs_dout[i] !== '0 || obs_ov[i] !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_outputs dut%0d: count=%0d d_out=%0d ov=%b, want 0/0/0", i, obs_cnt[i], obs_dout[i], obs_ov[i]);
            end
            for (int j = 0; j < cfg_k[i]; j++) begin
                n_checks++;
                if (obs_slot[i][j] !== '0) begin
                    n_fails++;
                    $display("FAIL reset_slot dut%0d[%0d]: got %0d want 0", i, j, obs_slot[i][j]);
                end
            end
            model_clear(i);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_k2_distinct();
        int unsigned s [6] = '{5, 1, 10, 7, 10, 3};
        int unsigned e [6] = '{0, 1, 5, 7, 7, 7};
        for (int n = 0; n < 6; n++) begin
            drive(0, 1'b1, 1'b0, s[n]);
            n_checks++;
            if (obs_dout[0] !== W'(e[n])) begin
                n_fails++;
                $display("FAIL k2_distinct d_out step %0d: got %0d want %0d", n, obs_dout[0], e[n]);
            end
            n_checks++;
            if (obs_ov[0] !== (n >= 1)) begin
                n_fails++;
                $display("FAIL k2_distinct out_valid step %0d: got %b want %b", n, obs_ov[0], (n >= 1));
            end
        end
        n_checks++;
        if (obs_slot[0][0] !== W'(10) || obs_slot[0][1] !== W'(7)) begin
            n_fails++;
            $display("FAIL k2_distinct top_all: got [%0d,%0d] want [10,7]", obs_slot[0][0], obs_slot[0][1]);
        end
    endtask

    task automatic test_k2_duplicates();
        int unsigned s [6] = '{5, 1, 10, 7, 10, 3};
        int unsigned e [6] = '{0, 1, 5, 7, 10, 10};
        for (int n = 0; n < 6; n++) begin
            drive(1, 1'b1, 1'b0, s[n]);
            n_checks++;
            if (obs_dout[1] !== W'(e[n]) || obs_cnt[1] !== ((n >= 1) ? 2 : 1)) begin
                n_fails++;
                $display("FAIL k2_dup step %0d: d_out=%0d count=%0d want d_out=%0d", n, obs_dout[1], obs_cnt[1], e[n]);
            end
        end
        n_checks++;
        if (obs_slot[1][0] !== W'(10) || obs_slot[1][1] !== W'(10)) begin
            n_fails++;
            $display("FAIL k2_dup top_all: got [%0d,%0d] want [10,10]", obs_slot[1][0], obs_slot[1][1]);
        end
    endtask

    task automatic test_k4_duplicates();
        int unsigned s [6] = '{8, 3, 8, 12, 1, 6};
        int unsigned c [6] = '{1, 2, 3, 4, 4, 4};
        int unsigned e [6] = '{0, 0, 0, 3, 3, 6};
        int unsigned f [4] = '{12, 8, 8, 6};
        for (int n = 0; n < 6; n++) begin
            drive(2, 1'b1, 1'b0, s[n]);
            n_checks++;
            if (obs_cnt[2] !== c[n] || obs_dout[2] !== W'(e[n])) begin
                n_fails++;
                $display("FAIL k4_dup step %0d: count=%0d d_out=%0d want count=%0d d_out=%0d", n, obs_cnt[2], obs_dout[2], c[n], e[n]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (obs_slot[2][j] !== W'(f[j])) begin
                n_fails++;
                $display("FAIL k4_dup slot %0d: got %0d want %0d", j, obs_slot[2][j], f[j]);
            end
        end
    endtask

    task automatic test_k3_min();
        int unsigned s [6] = '{9, 4, 4, 7, 2, 5};
        int unsigned c [6] = '{1, 2, 2, 3, 3, 3};
        int unsigned e [6] = '{0, 0, 0, 9, 7, 5};
        int unsigned f [3] = '{2, 4, 5};
        for (int n = 0; n < 6; n++) begin
            drive(3, 1'b1, 1'b0, s[n]);
            n_checks++;
            if (obs_cnt[3] !== c[n] || obs_dout[3] !== W'(e[n])) begin
                n_fails++;
                $display("FAIL k3_min step %0d: count=%0d d_out=%0d want count=%0d d_out=%0d", n, obs_cnt[3], obs_dout[3], c[n], e[n]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (obs_slot[3][j] !== W'(f[j])) begin
                n_fails++;
                $display("FAIL k3_min slot %0d: got %0d want %0d", j, obs_slot[3][j], f[j]);
            end
        end
    endtask

    task automatic test_control();
        // Idle cycles with a toggling sample must not disturb the list.
        for (int n = 0; n < 4; n++) begin
            drive(2, 1'b0, 1'b0, (n % 2 == 0) ? 100 : 0);
            n_checks++;
            if (obs_cnt[2] !== 4 || obs_slot[2][0] !== W'(12) || obs_slot[2][3] !== W'(6) || obs_dout[2] !== W'(6)) begin
                n_fails++;
                $display("FAIL idle_hold cycle %0d: count=%0d s0=%0d s3=%0d d_out=%0d", n, obs_cnt[2], obs_slot[2][0], obs_slot[2][3], obs_dout[2]);
            end
        end
        drive(2, 1'b1, 1'b1, 99);
        n_checks++;
        if (obs_cnt[2] !== 0 || obs_dout[2] !== '0 || obs_ov[2] !== 1'b0) begin
            n_fails++;
            $display("FAIL clear_outputs: count=%0d d_out=%0d ov=%b want 0/0/0", obs_cnt[2], obs_dout[2], obs_ov[2]);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (obs_slot[2][j] !== '0) begin
                n_fails++;
                $display("FAIL clear_slot %0d: got %0d want 0", j, obs_slot[2][j]);
            end
        end
        drive(2, 1'b1, 1'b0, 4);
        n_checks++;
        if (obs_cnt[2] !== 1 || obs_slot[2][0] !== W'(4) || obs_slot[2][1] !== '0 || obs_dout[2] !== '0) begin
            n_fails++;
            $display("FAIL after_clear: count=%0d s0=%0d s1=%0d d_out=%0d want 1/4/0/0", obs_cnt[2], obs_slot[2][0], obs_slot[2][1], obs_dout[2]);
        end
    endtask

    task automatic test_random();
        int unsigned d;
        int r;
        bit v;
        bit c;
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b0, 1'b1, 0);
            for (int n = 0; n < 300; n++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6)      d = $urandom_range(0, 15);
                else if (r < 8) d = (r == 6) ? 0 : 32'hffff;
                else            d = $urandom_range(0, 65535);
                v = ($urandom_range(0, 4) != 0);
                c = ($urandom_range(0, 39) == 0);
                drive(i, v, c, d);
                n_checks++;
                if (obs_cnt[i] !== m_cnt[i] || obs_dout[i] !== W'(model_dout(i)) ||
                    obs_ov[i] !== (m_cnt[i] == cfg_k[i])) begin
                    n_fails++;
                    $display("FAIL random dut%0d step %0d: count=%0d d_out=%0d ov=%b want count=%0d d_out=%0d",
                             i, n, obs_cnt[i], obs_dout[i], obs_ov[i], m_cnt[i], model_dout(i));
                end
                for (int j = 0; j < cfg_k[i]; j++) begin
                    n_checks++;
                    if (obs_slot[i][j] !== W'(m_slot[i][j])) begin
                        n_fails++;
                        $display("FAIL random_slot dut%0d step %0d slot %0d: got %0d want %0d",
                                 i, n, j, obs_slot[i][j], m_slot[i][j]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1'b1, 1'b0, 3);
        drive(0, 1'b1, 1'b0, 9);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_cnt[i] !== 0 || obs_dout[i] !== '0 || obs_ov[i] !== 1'b0 ||
                    obs_slot[i][0] !== '0 || obs_slot[i][1] !== '0) begin
                    n_fails++;
                    $display("FAIL async_reset pass %0d dut%0d: count=%0d d_out=%0d ov=%b s0=%0d s1=%0d",
                             pass, i, obs_cnt[i], obs_dout[i], obs_ov[i], obs_slot[i][0], obs_slot[i][1]);
                end
            end
            drv_valid[0] = 1'b1;
            drv_d[0]     = W'(50);
            @(posedge clk);
            #1;
            drv_valid[0] = 1'b0;
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model_clear(i);
        test_k2_distinct();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            drv_clear[i] = 1'b0;
            drv_valid[i] = 1'b0;
            drv_d[i]     = '0;
        end
        test_reset();
        test_k2_distinct();
        test_k2_duplicates();
        test_k4_duplicates();
        test_k3_min();
        test_control();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
